// File: rtl/dec.sv
// dec: binary-to-one-hot decoder with optional output register and selectable polarity
module dec #(
  parameter int IN_W       = 3,
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit REG_OUT    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [IN_W-1:0]      a,
  output logic [2**IN_W-1:0]   x,
  output logic                 valid
);
  localparam int OUT_W = 2**IN_W;
  logic [OUT_W-1:0] d, q;
  logic v;
  // an unknown code decodes to nothing rather than smearing X across lines
  always_comb begin
    d = '0;
    if (en && !$isunknown(a)) d[a] = 1'b1;
  end
  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
          v <= 1'b0;
        end else begin
          q <= d;
          v <= en;
        end
      end
    end else begin : g_comb
      always_comb begin
        q = d;
        v = en;
      end
    end
  endgenerate
  assign x     = ACTIVE_LOW ? ~q : q;
  assign valid = v;
endmodule

// File: tb/tb_dec.sv
// tb_dec: randomized and directed checks of dec in registered, active-low, combinational and wide variants
module tb_dec;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [2:0] a = '0;
  logic [3:0] a4 = '0;
  logic [7:0] x, xl, xc;
  logic [15:0] x4;
  logic v, vl, vc, v4;
  int checks = 0, errors = 0;

  dec u_def (.clk(clk), .rst(rst), .en(en), .a(a), .x(x), .valid(v));
  dec #(.ACTIVE_LOW(1'b1)) u_low (.clk(clk), .rst(rst), .en(en), .a(a), .x(xl), .valid(vl));
  dec #(.REG_OUT(1'b0)) u_comb (.clk(clk), .rst(rst), .en(en), .a(a), .x(xc), .valid(vc));
  dec #(.IN_W(4)) u_w4 (.clk(clk), .rst(rst), .en(en), .a(a4), .x(x4), .valid(v4));

  always #5 clk = ~clk;

  function automatic logic [7:0] hot(input logic e, input logic [2:0] s);
    logic [7:0] one = 8'd1;
    return e ? one << s : 8'h00;
  endfunction

  function automatic logic [15:0] hot4(input logic e, input logic [3:0] s);
    logic [15:0] one = 16'd1;
    return e ? one << s : 16'h0000;
  endfunction

  task automatic drive(input logic e, input logic [2:0] s);
    @(negedge clk);
    en = e;
    a  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (x !== 8'h00) begin errors++; $display("FAIL reset_x got %h want 00", x); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", v); end
    checks++; if (xl !== 8'hFF) begin errors++; $display("FAIL reset_x_low got %h want ff", xl); end
    checks++; if (x4 !== 16'h0000) begin errors++; $display("FAIL reset_x4 got %h want 0000", x4); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 3'(s));
      checks++; if (x !== hot(1'b1, 3'(s))) begin errors++; $display("FAIL sweep_x code %0d got %h want %h", s, x, hot(1'b1, 3'(s))); end
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL sweep_valid code %0d got %b want 1", s, v); end
    end
  endtask

  task automatic test_enable();
    drive(1'b0, 3'b101);
    checks++; if (x !== 8'h00 || v !== 1'b0) begin errors++; $display("FAIL en_low got x=%h v=%b want x=00 v=0", x, v); end
    drive(1'b1, 3'b101);
    checks++; if (x !== 8'h20 || v !== 1'b1) begin errors++; $display("FAIL en_rise got x=%h v=%b want x=20 v=1", x, v); end
  endtask

  task automatic test_polarity();
    drive(1'b1, 3'b010);
    checks++; if (xl !== 8'hFB || vl !== 1'b1) begin errors++; $display("FAIL polarity got x=%h v=%b want x=fb v=1", xl, vl); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 3'd4);
    checks++; if (x !== 8'h10) begin errors++; $display("FAIL pre_rst got %h want 10", x); end
    #2 rst = 1'b1;
    #1;
    checks++; if (x !== 8'h00 || v !== 1'b0) begin errors++; $display("FAIL async_rst got x=%h v=%b want x=00 v=0", x, v); end
    checks++; if (xl !== 8'hFF || vl !== 1'b0) begin errors++; $display("FAIL async_rst_low got x=%h v=%b want x=ff v=0", xl, vl); end
    checks++; if (xc !== 8'h10 || vc !== 1'b1) begin errors++; $display("FAIL rst_comb got x=%h v=%b want x=10 v=1", xc, vc); end
    @(posedge clk);
    #1;
    checks++; if (x !== 8'h00) begin errors++; $display("FAIL rst_hold got %h want 00", x); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (x !== 8'h10 || v !== 1'b1) begin errors++; $display("FAIL rst_release got x=%h v=%b want x=10 v=1", x, v); end
  endtask

  task automatic test_comb();
    for (int s = 0; s < 8; s++) begin
      en = 1'b1;
      a  = 3'(s);
      #1;
      checks++; if (xc !== hot(1'b1, 3'(s)) || vc !== 1'b1) begin errors++; $display("FAIL comb code %0d got x=%h v=%b want x=%h v=1", s, xc, vc, hot(1'b1, 3'(s))); end
      #99;
    end
    en = 1'b0;
    #1;
    checks++; if (xc !== 8'h00 || vc !== 1'b0) begin errors++; $display("FAIL comb_off got x=%h v=%b want x=00 v=0", xc, vc); end
  endtask

  task automatic test_width();
    @(negedge clk);
    en = 1'b1;
    a4 = 4'hF;
    @(posedge clk);
    #1;
    checks++; if (x4 !== 16'h8000 || v4 !== 1'b1) begin errors++; $display("FAIL width got x=%h v=%b want x=8000 v=1", x4, v4); end
  endtask

  task automatic test_random();
    logic e;
    logic [2:0] s;
    logic [3:0] s4;
    for (int i = 0; i < 60; i++) begin
      e  = ($urandom_range(0, 3) != 0);
      s  = 3'($urandom);
      s4 = 4'($urandom);
      @(negedge clk);
      en = e;
      a  = s;
      a4 = s4;
      #1;
      checks++; if (xc !== hot(e, s) || $countones(xc) != int'(e)) begin errors++; $display("FAIL rand_comb got %h want %h", xc, hot(e, s)); end
      @(posedge clk);
      #1;
      checks++; if (x !== hot(e, s) || v !== e || $countones(x) != int'(e)) begin errors++; $display("FAIL rand_reg got x=%h v=%b want x=%h v=%b", x, v, hot(e, s), e); end
      checks++; if (xl !== ~hot(e, s) || vl !== e) begin errors++; $display("FAIL rand_low got x=%h v=%b want x=%h v=%b", xl, vl, ~hot(e, s), e); end
      checks++; if (x4 !== hot4(e, s4) || $countones(x4) != int'(e)) begin errors++; $display("FAIL rand_w4 got %h want %h", x4, hot4(e, s4)); end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_enable();
    test_polarity();
    test_async_reset();
    test_width();
    test_random();
    test_comb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
